// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and the 64-bit dmem word port.
// Every store is done as a read-modify-write of a whole dword. Accesses that
// cross a dword boundary take two word cycles (LO, then HI at word+1).
module dmem_access_ctrl #(
    parameter int N                = 64,
    parameter int ADDR_W           = 12,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int CNT_W            = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W+2:0]   req_addr,
    input  logic [2:0]          req_width,
    input  logic [N-1:0]        req_wdata,
    output logic                rsp_valid,
    output logic [N-1:0]        rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [CNT_W-1:0]    split_cnt,
    output logic [ADDR_W-1:0]   dm_wordAddr,
    output logic                dm_readEnable,
    output logic                dm_writeEnable,
    output logic [2:0]          dm_memWidth,
    output logic [2:0]          dm_byteOffset,
    output logic [N-1:0]        dm_writeData,
    input  logic [N-1:0]        dm_readData
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, err_q, err_d, cross_q, cross_d;
    logic [ADDR_W-1:0]   word_q, word_d, addr_q, addr_d;
    logic [2:0]          off_q, off_d, width_q, width_d;
    logic [N-1:0]        wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d;
    logic [CNT_W-1:0]    split_cnt_q, split_cnt_d;

    // request decode, evaluated on the incoming request at accept time
    logic [3:0]          in_size;
    logic                in_cross, in_mis, in_err, accept;
    logic [2*N-1:0]      win;
    logic [N-1:0]        ext, merged;

    assign accept   = req_valid && req_ready;
    assign in_size  = 4'd1 << req_width[1:0];
    assign in_cross = ({1'b0, req_addr[2:0]} + in_size) > 4'd8;
    assign in_mis   = (req_addr[2:0] & (in_size[2:0] - 3'd1)) != 3'd0;
    // a crossing access in the last word would wrap to word 0: reject instead
    assign in_err   = (req_width == 3'b111) || (in_cross && (&req_addr[ADDR_W+2:3])) ||
                      (in_mis && (ALLOW_MISALIGNED == 0));

    // load data: little-endian window starting at the byte offset, then extend
    assign win = {hi_q, lo_q} >> {off_q, 3'b000};
    always_comb begin
        ext = win[N-1:0];
        unique case (width_q[1:0])
            2'd0: ext = width_q[2] ? {56'd0, win[7:0]}  : {{56{win[7]}},  win[7:0]};
            2'd1: ext = width_q[2] ? {48'd0, win[15:0]} : {{48{win[15]}}, win[15:0]};
            2'd2: ext = width_q[2] ? {32'd0, win[31:0]} : {{32{win[31]}}, win[31:0]};
            default: ext = win[N-1:0];
        endcase
    end

    // store merge: byte b of the current word is byte j of a 16-byte window
    // (j = b in LO, b+8 in HI); replace it when it falls inside the access
    always_comb begin
        int offi, sizei, jb;
        merged = dm_readData;
        offi   = int'(off_q);
        sizei  = 1 << width_q[1:0];
        for (int b = 0; b < 8; b++) begin
            jb = b + ((state_q == HI) ? 8 : 0);
            if (jb >= offi && jb < offi + sizei)
                merged[8*b +: 8] = wdata_q[8*(jb-offi) +: 8];
        end
    end

    // next-state, datapath captures and dmem strobes
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        err_d          = err_q;
        cross_d        = cross_q;
        word_d         = word_q;
        off_d          = off_q;
        width_d        = width_q;
        wdata_d        = wdata_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        split_cnt_d    = split_cnt_q;
        dm_wordAddr    = addr_q;
        dm_readEnable  = 1'b0;
        dm_writeEnable = 1'b0;
        dm_writeData   = merged;
        unique case (state_q)
            LO: begin
                // an errored request spends this slot idle so RESP timing matches
                if (!err_q) begin
                    dm_wordAddr    = word_q;
                    dm_readEnable  = 1'b1;
                    dm_writeEnable = we_q && !reset;
                    lo_d           = dm_readData;
                end
                state_d = (cross_q && !err_q) ? HI : RESP;
            end
            HI: begin
                dm_wordAddr    = word_q + 1'b1;
                dm_readEnable  = 1'b1;
                dm_writeEnable = we_q && !reset;
                hi_d           = dm_readData;
                if (split_cnt_q != '1) split_cnt_d = split_cnt_q + 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = LO;
            we_d    = req_we;
            err_d   = in_err;
            cross_d = in_cross;
            word_d  = req_addr[ADDR_W+2:3];
            off_d   = req_addr[2:0];
            width_d = req_width;
            wdata_d = req_wdata;
            hi_d    = '0;
        end
        addr_d = dm_wordAddr;
    end

    // state register; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            split_cnt_q <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            we_q        <= we_d;
            split_cnt_q <= split_cnt_d;
            addr_q      <= addr_d;
        end
    end

    // request and data registers; contents only matter after an accept
    always_ff @(posedge clk) begin
        cross_q <= cross_d;
        word_q  <= word_d;
        off_q   <= off_d;
        width_q <= width_d;
        wdata_q <= wdata_d;
        lo_q    <= lo_d;
        hi_q    <= hi_d;
    end

    assign req_ready     = (state_q == IDLE) || (state_q == RESP);
    assign busy          = state_q != IDLE;
    assign rsp_valid     = state_q == RESP;
    assign rsp_err       = (state_q == RESP) && err_q;
    assign rsp_rdata     = ((state_q == RESP) && !we_q && !err_q) ? ext : '0;
    assign split_cnt     = split_cnt_q;
    assign dm_memWidth   = 3'b011;
    assign dm_byteOffset = 3'b000;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 4K x 64 dmem per DUT.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid2, req_we;
    logic [14:0] req_addr;
    logic [2:0]  req_width;
    logic [63:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [63:0] rsp_rdata;
    logic [15:0] split_cnt;
    logic [11:0] dm_wordAddr;
    logic        dm_readEnable, dm_writeEnable;
    logic [2:0]  dm_memWidth, dm_byteOffset;
    logic [63:0] dm_writeData, dm_readData;
    // second instance: misaligned accesses rejected
    logic        req_ready2, rsp_valid2, rsp_err2, busy2;
    logic [63:0] rsp_rdata2;
    logic [15:0] split_cnt2;
    logic [11:0] dm_wordAddr2;
    logic        dm_readEnable2, dm_writeEnable2;
    logic [2:0]  dm_memWidth2, dm_byteOffset2;
    logic [63:0] dm_writeData2, dm_readData2;

    logic [63:0] mem  [4096];
    logic [63:0] mem2 [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [63:0] pre_data;
    int          wcnt = 0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .split_cnt(split_cnt), .dm_wordAddr(dm_wordAddr), .dm_readEnable(dm_readEnable),
        .dm_writeEnable(dm_writeEnable), .dm_memWidth(dm_memWidth),
        .dm_byteOffset(dm_byteOffset), .dm_writeData(dm_writeData), .dm_readData(dm_readData));

    dmem_access_ctrl #(.ALLOW_MISALIGNED(0)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we), .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2),
        .split_cnt(split_cnt2), .dm_wordAddr(dm_wordAddr2), .dm_readEnable(dm_readEnable2),
        .dm_writeEnable(dm_writeEnable2), .dm_memWidth(dm_memWidth2),
        .dm_byteOffset(dm_byteOffset2), .dm_writeData(dm_writeData2), .dm_readData(dm_readData2));

    assign dm_readData  = mem[dm_wordAddr];
    assign dm_readData2 = mem2[dm_wordAddr2];

    // dmem models: bench preload port has priority, DUT writes land on posedge
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (dm_writeEnable) mem[dm_wordAddr] <= dm_writeData;
        if (dm_writeEnable) wcnt <= wcnt + 1;
        if (dm_writeEnable2) mem2[dm_wordAddr2] <= dm_writeData2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // issue one request (sel=1 -> second instance), return response and latency
    task automatic do_req(input bit sel, input logic we, input logic [14:0] a,
                          input logic [2:0] w, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
        req_we = we; req_addr = a; req_width = w; req_wdata = d;
        if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_valid2 = 1'b0;
        lat = 1;
        while (!(sel ? rsp_valid2 : rsp_valid) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!(sel ? rsp_valid2 : rsp_valid)) check("rsp_timeout", 64'd0, 64'd1);
        rd = sel ? rsp_rdata2 : rsp_rdata;
        er = sel ? rsp_err2 : rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat, w0;
        reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0;
        req_addr = '0; req_width = '0; req_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(negedge clk); @(negedge clk);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_we", {63'd0, dm_writeEnable}, 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_split", {48'd0, split_cnt}, 64'd0);

        // 1: aligned SD then LD
        do_req(0, 1, 15'h0008, 3'b011, 64'h1122334455667788, rd, er, lat);
        check("sd_lat", 64'(lat), 64'd2);
        check("sd_err", {63'd0, er}, 64'd0);
        check("sd_mem", mem[1], 64'h1122334455667788);
        do_req(0, 0, 15'h0008, 3'b011, 64'd0, rd, er, lat);
        check("ld_lat", 64'(lat), 64'd2);
        check("ld_data", rd, 64'h1122334455667788);
        check("ld_split", {48'd0, split_cnt}, 64'd0);

        // 2: crossing LW / LWU
        preload(12'd2, 64'h8877665544332211);
        preload(12'd3, 64'h00000000000000FF);
        do_req(0, 0, 15'h0015, 3'b010, 64'd0, rd, er, lat);
        check("lw_lat", 64'(lat), 64'd3);
        check("lw_data", rd, 64'hFFFFFFFFFF887766);
        check("lw_split", {48'd0, split_cnt}, 64'd1);
        do_req(0, 0, 15'h0015, 3'b110, 64'd0, rd, er, lat);
        check("lwu_data", rd, 64'h00000000FF887766);
        check("lwu_split", {48'd0, split_cnt}, 64'd2);

        // 3: crossing SH
        do_req(0, 1, 15'h000F, 3'b001, 64'h000000000000ABCD, rd, er, lat);
        check("sh_lat", 64'(lat), 64'd3);
        check("sh_w1", mem[1], 64'hCD22334455667788);
        check("sh_w2", mem[2], 64'h88776655443322AB);
        check("sh_w3", mem[3], 64'h00000000000000FF);

        // 4: crossing in last word -> err, no write
        preload(12'hFFF, 64'h0123456789ABCDEF);
        w0 = wcnt;
        do_req(0, 1, 15'h7FFC, 3'b011, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        check("wrap_lat", 64'(lat), 64'd2);
        check("wrap_err", {63'd0, er}, 64'd1);
        check("wrap_mem", mem[4095], 64'h0123456789ABCDEF);
        check("wrap_wcnt", 64'(wcnt - w0), 64'd0);

        // 5: reset during HI of a crossing SW
        preload(12'h020, 64'd0);
        preload(12'h021, 64'h5A5A5A5A5A5A5A5A);
        req_we = 1'b1; req_addr = 15'h0106; req_width = 3'b010; req_wdata = 64'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst5_rsp", {63'd0, rsp_valid}, 64'd0);
        check("rst5_busy", {63'd0, busy}, 64'd0);
        check("rst5_ready", {63'd0, req_ready}, 64'd1);
        check("rst5_lo", mem[12'h020], 64'hBEEF000000000000);
        check("rst5_hi", mem[12'h021], 64'h5A5A5A5A5A5A5A5A);
        @(negedge clk);
        check("rst5_rsp2", {63'd0, rsp_valid}, 64'd0);

        // 6: request held valid through RESP is accepted back-to-back
        req_we = 1'b0; req_addr = 15'h0008; req_width = 3'b011; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("b2b_ready_lo", {63'd0, req_ready}, 64'd0);
        req_addr = 15'h0010;
        @(negedge clk);
        check("b2b_rsp_a", {63'd0, rsp_valid}, 64'd1);
        check("b2b_data_a", rsp_rdata, 64'hCD22334455667788);
        check("b2b_ready_resp", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_busy_b", {63'd0, busy}, 64'd1);
        check("b2b_norsp", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("b2b_rsp_b", {63'd0, rsp_valid}, 64'd1);
        check("b2b_data_b", rsp_rdata, 64'h88776655443322AB);
        @(negedge clk);

        do_req(0, 0, 15'h0008, 3'b111, 64'd0, rd, er, lat);
        check("w111_err", {63'd0, er}, 64'd1);
        check("w111_rdata", rd, 64'd0);
        do_req(1, 0, 15'h0001, 3'b001, 64'd0, rd, er, lat);
        check("nomis_err", {63'd0, er}, 64'd1);
        check("nomis_lat", 64'(lat), 64'd2);
        do_req(1, 0, 15'h0004, 3'b010, 64'd0, rd, er, lat);
        check("nomis_aligned_err", {63'd0, er}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
